// File: rtl/run_seq_pkg.sv
// Shared types and default configuration for the run sequencer.
// State encoding, default memory window constants and bus typedefs.
package run_seq_pkg;

   localparam int DEF_AW        = 8;
   localparam int DEF_DW        = 8;
   localparam int DEF_LOAD_BASE = 0;
   localparam int DEF_LOAD_LEN  = 64;
   localparam int DEF_RES_BASE  = 64;
   localparam int DEF_RES_LEN   = 32;
   localparam int DEF_CW        = 16;
   localparam int DEF_TIMEOUT   = 4096;

   typedef logic [DEF_AW-1:0] addr_t;
   typedef logic [DEF_DW-1:0] data_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/seq_counter.sv
// Clear/enable counter that sticks at all-ones; one-cycle update latency.
// No backpressure: i_en is sampled every cycle, i_clr has priority over i_en.
module seq_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/run_sequencer.sv
// Host sequencer: load image, run core, drain results; memory writes are same-cycle with the handshake.
// Load/drain stall on in_valid/out_ready; watchdog exit from RUN only when built with TIMEOUT_EN.
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int LOAD_BASE = DEF_LOAD_BASE,
   parameter int LOAD_LEN  = DEF_LOAD_LEN,
   parameter int RES_BASE  = DEF_RES_BASE,
   parameter int RES_LEN   = DEF_RES_LEN,
   parameter int CW        = DEF_CW,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          host_start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          mem_sel,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdat,
   input  logic [DW-1:0] mem_rdat,
   output logic          core_reset,
   output logic          core_req,
   input  logic          core_done,
   output logic          busy,
   output logic          host_done,
   output logic          timeout,
   output logic [CW-1:0] run_cycles
);

`ifdef TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam logic [AW-1:0] LD_BASE = AW'(LOAD_BASE);
   localparam logic [AW-1:0] RS_BASE = AW'(RES_BASE);
   localparam logic [AW:0]   LD_LAST = (AW+1)'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
   localparam logic [AW:0]   RD_LAST = (AW+1)'((RES_LEN > 0) ? RES_LEN - 1 : 0);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        r_state;
   state_t        w_next;
   logic          r_timeout;
   logic          w_clr;
   logic          w_ld_en;
   logic          w_rd_en;
   logic          w_run_en;
   logic          w_set_to;
   logic          w_first;
   logic [AW:0]   w_ld_cnt;
   logic [AW:0]   w_rd_cnt;
   logic [CW-1:0] w_run_cnt;

   seq_counter #(.W(AW+1)) u_ld_cnt (
      .i_clk(clk), .i_rst_n(reset), .i_clr(w_clr), .i_en(w_ld_en), .o_cnt(w_ld_cnt)
   );

   seq_counter #(.W(AW+1)) u_rd_cnt (
      .i_clk(clk), .i_rst_n(reset), .i_clr(w_clr), .i_en(w_rd_en), .o_cnt(w_rd_cnt)
   );

   seq_counter #(.W(CW)) u_run_cnt (
      .i_clk(clk), .i_rst_n(reset), .i_clr(w_clr), .i_en(w_run_en), .o_cnt(w_run_cnt)
   );

   // Run counter is still zero only during the first RUN cycle of a run.
   assign w_first    = (w_run_cnt == '0);
   assign run_cycles = w_run_cnt;
   assign timeout    = r_timeout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_clr) begin
            r_timeout <= 1'b0;
         end else if (w_set_to) begin
            r_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_clr      = 1'b0;
      w_ld_en    = 1'b0;
      w_rd_en    = 1'b0;
      w_run_en   = 1'b0;
      w_set_to   = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      mem_sel    = 1'b1;
      mem_wr_en  = 1'b0;
      mem_addr   = '0;
      mem_wdat   = '0;
      core_reset = 1'b1;
      core_req   = 1'b0;
      busy       = 1'b0;
      host_done  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            host_done = (r_state == S_DONE);
            if (host_start) begin
               w_clr  = 1'b1;
               w_next = (LOAD_LEN == 0) ? S_RUN : S_LOAD;
            end
         end
         S_LOAD: begin
            busy      = 1'b1;
            in_ready  = 1'b1;
            mem_addr  = LD_BASE + w_ld_cnt[AW-1:0];
            mem_wdat  = in_data;
            mem_wr_en = in_valid;
            w_ld_en   = in_valid;
            if (in_valid && (w_ld_cnt == LD_LAST)) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            busy       = 1'b1;
            mem_sel    = 1'b0;
            core_reset = 1'b0;
            core_req   = w_first;
            w_run_en   = 1'b1;
            // A done level seen in the first cycle is left over from the previous run.
            if (core_done && !w_first) begin
               w_next = (RES_LEN == 0) ? S_DONE : S_DRAIN;
            end else if (TO_EN && (w_run_cnt == TO_LAST)) begin
               w_next   = S_DONE;
               w_set_to = 1'b1;
            end
         end
         S_DRAIN: begin
            busy      = 1'b1;
            mem_addr  = RS_BASE + w_rd_cnt[AW-1:0];
            out_valid = 1'b1;
            out_data  = mem_rdat;
            w_rd_en   = out_ready;
            if (out_ready && (w_rd_cnt == RD_LAST)) begin
               w_next = S_DONE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboarded bench: a load/run/drain driver pushes expectations, negedge monitors pop and compare.
module tb_run_sequencer;

`ifdef TIMEOUT_EN
   localparam int DONE_DIR = 8;
   localparam int DMAX     = 8;
`else
   localparam int DONE_DIR = 10;
   localparam int DMAX     = 30;
`endif
   localparam int TMO = 8;

   logic        clk, rst_n;
   logic        host_start, in_valid, in_ready, out_valid, out_ready;
   logic        mem_sel, mem_wr_en, core_reset, core_req, core_done;
   logic        busy, host_done, timeout;
   logic [7:0]  in_data, out_data, mem_addr, mem_wdat, mem_rdat;
   logic [15:0] run_cycles;
   logic        c_we;
   logic [7:0]  c_addr, c_dat;
   logic [7:0]  mem [256];

   logic        b_host_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic        b_mem_sel, b_mem_wr_en, b_core_reset, b_core_req, b_core_done;
   logic        b_busy, b_host_done, b_timeout;
   logic [7:0]  b_in_data, b_out_data, b_mem_addr, b_mem_wdat, b_mem_rdat;
   logic [15:0] b_run_cycles;
   int          b_bad;

   logic [15:0] exp_wr[$];
   logic [7:0]  exp_out[$];
   int          n_checks, n_pass;

   run_sequencer #(.AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(4), .RES_BASE(64),
                   .RES_LEN(2), .CW(16), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(rst_n), .host_start(host_start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
      .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
      .busy(busy), .host_done(host_done), .timeout(timeout), .run_cycles(run_cycles)
   );

   run_sequencer #(.AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(0), .RES_BASE(64),
                   .RES_LEN(0), .CW(16), .TIMEOUT(TMO)) dut_zero (
      .clk(clk), .reset(rst_n), .host_start(b_host_start),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .mem_sel(b_mem_sel), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr),
      .mem_wdat(b_mem_wdat), .mem_rdat(b_mem_rdat),
      .core_reset(b_core_reset), .core_req(b_core_req), .core_done(b_core_done),
      .busy(b_busy), .host_done(b_host_done), .timeout(b_timeout), .run_cycles(b_run_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory shared between sequencer and emulated core, muxed on mem_sel.
   assign mem_rdat = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_sel ? mem_wr_en : c_we)
         mem[mem_sel ? mem_addr : c_addr] <= mem_sel ? mem_wdat : c_dat;
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endfunction

   function automatic void flag(string name);
      n_checks++;
      $display("FAIL %s: transfer seen with nothing expected (required none)", name);
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_wr_en) begin
            if (exp_wr.size() == 0) flag("wr_unexpected");
            else begin
               logic [15:0] e;
               e = exp_wr.pop_front();
               check("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
               check("wr_data", {24'd0, mem_wdat}, {24'd0, e[7:0]});
            end
         end
         if (out_valid) begin
            if (exp_out.size() == 0) flag("out_unexpected");
            else if (out_ready) check("out_data", {24'd0, out_data}, {24'd0, exp_out.pop_front()});
            else check("out_stall_data", {24'd0, out_data}, {24'd0, exp_out[0]});
         end
         if (b_mem_wr_en || b_out_valid) b_bad++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_core(input int done_at, input bit stale, input bit push,
                           input bit directed, output int ncyc);
      int t;
      int reqs;
      t = 0;
      ncyc = 0;
      reqs = 0;
      while (core_reset && t < 200) begin
         tick();
         t++;
      end
      if (core_reset) begin
         check("run_entry_core_reset", {31'd0, core_reset}, 32'd0);
         return;
      end
      while (!core_reset && ncyc < 5000) begin
         ncyc++;
         if (core_req) reqs++;
         if (ncyc == 1) check("core_req_first", {31'd0, core_req}, 32'd1);
         core_done  = (ncyc == 1 && stale) || (ncyc == done_at);
         host_start = (ncyc == 3);
         if (ncyc <= 2) begin
            c_we   = 1'b1;
            c_addr = 8'(64 + ncyc - 1);
            c_dat  = directed ? ((ncyc == 1) ? 8'hA5 : 8'h5A) : 8'($urandom);
            if (push) exp_out.push_back(c_dat);
         end else begin
            c_we = 1'b0;
         end
         tick();
      end
      core_done  = 1'b0;
      host_start = 1'b0;
      c_we       = 1'b0;
      check("core_req_pulses", reqs, 32'd1);
   endtask

   task automatic drain(input bit directed);
      int t;
      int stalls;
      t = 0;
      stalls = 0;
      while (!host_done && t < 500) begin
         if (directed) begin
            out_ready = out_valid && (stalls >= 3);
            if (out_valid && !out_ready) stalls++;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         tick();
         t++;
      end
      out_ready = 1'b0;
   endtask

   task automatic do_run(input bit directed, input int done_at, input bit stale, input bit to_run);
      int ncyc;
      int exp_cyc;
      logic [7:0] b;
      exp_cyc = to_run ? TMO : done_at;
      host_start = 1'b1;
      tick();
      host_start = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_host_done", {31'd0, host_done}, 32'd0);
      check("start_run_cycles", {16'd0, run_cycles}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         repeat (directed ? 1 : $urandom_range(0, 2)) tick();
         b = directed ? 8'((i + 1) * 17) : 8'($urandom);
         in_valid = 1'b1;
         in_data  = b;
         exp_wr.push_back({8'(i), b});
         tick();
         in_valid = 1'b0;
      end
      run_core(done_at, stale, !to_run, directed, ncyc);
      check("run_length", ncyc, exp_cyc);
      drain(directed);
      check("done_host_done", {31'd0, host_done}, 32'd1);
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_run_cycles", {16'd0, run_cycles}, exp_cyc);
      check("done_timeout", {31'd0, timeout}, {31'd0, to_run});
      check("done_core_reset", {31'd0, core_reset}, 32'd1);
      check("done_out_queue", exp_out.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_pass = 0; b_bad = 0;
      rst_n = 1'b0; host_start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      out_ready = 1'b0; core_done = 1'b0; c_we = 1'b0; c_addr = 8'd0; c_dat = 8'd0;
      b_host_start = 1'b0; b_in_valid = 1'b1; b_in_data = 8'hFF;
      b_out_ready = 1'b1; b_mem_rdat = 8'h00; b_core_done = 1'b0;
      repeat (3) tick();
      check("rst_core_reset", {31'd0, core_reset}, 32'd1);
      check("rst_mem_sel", {31'd0, mem_sel}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_host_done", {31'd0, host_done}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_core_req", {31'd0, core_req}, 32'd0);
      check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
      rst_n = 1'b1;
      tick();

      do_run(1'b1, DONE_DIR, 1'b0, 1'b0);

      host_start = 1'b1;
      tick();
      host_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         exp_wr.push_back({8'(i), in_data});
         tick();
         in_valid = 1'b0;
      end
      rst_n = 1'b0;
      #2;
      check("midrst_core_reset", {31'd0, core_reset}, 32'd1);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_mem_sel", {31'd0, mem_sel}, 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_wr_queue", exp_wr.size(), 32'd0);

      repeat (5) do_run(1'b0, $urandom_range(3, DMAX), 1'($urandom_range(0, 1)), 1'b0);
`ifdef TIMEOUT_EN
      do_run(1'b0, 0, 1'b0, 1'b1);
`endif

      b_host_start = 1'b1;
      tick();
      b_host_start = 1'b0;
      check("zero_core_reset", {31'd0, b_core_reset}, 32'd0);
      check("zero_core_req", {31'd0, b_core_req}, 32'd1);
      check("zero_busy", {31'd0, b_busy}, 32'd1);
      tick();
      tick();
      b_core_done = 1'b1;
      tick();
      b_core_done = 1'b0;
      check("zero_host_done", {31'd0, b_host_done}, 32'd1);
      check("zero_busy_end", {31'd0, b_busy}, 32'd0);
      check("zero_run_cycles", {16'd0, b_run_cycles}, 32'd3);
      check("zero_timeout", {31'd0, b_timeout}, 32'd0);
      check("zero_mem_sel", {31'd0, b_mem_sel}, 32'd1);
      check("zero_in_ready", {31'd0, b_in_ready}, 32'd0);
      check("zero_no_transfers", b_bad, 32'd0);

      tick();
      check("final_wr_queue", exp_wr.size(), 32'd0);
      check("final_out_queue", exp_out.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Host-side sequencer placed directly upstream of the top_level processor core.
- Streams a byte image into data memory over a valid/ready port.
- Releases the core from reset and pulses its req.
- Waits for the core's done, with an optional watchdog.
- Streams a result window back out of data memory.
- Owns the dat_mem write/address port whenever the core is held in reset; top-level muxes dat_mem inputs on mem_sel.

Parameters:
AW, 8, data-memory address width
DW, 8, data width
LOAD_BASE, 0, first address written during load
LOAD_LEN, 64, bytes loaded per run (0..2^AW)
RES_BASE, 64, first address read during drain
RES_LEN, 32, bytes drained per run (0..2^AW)
CW, 16, run-cycle counter width
TIMEOUT, 4096, watchdog limit in RUN cycles (used only with TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
host_start  in  1  one-cycle request to begin a run
in_valid  in  1  load byte valid
in_ready  out  1  sequencer accepts load byte
in_data  in  DW  load byte
out_valid  out  1  result byte valid
out_ready  in  1  host accepts result byte
out_data  out  DW  result byte
mem_sel  out  1  1 = sequencer drives dat_mem port
mem_wr_en  out  1  data-memory write strobe
mem_addr  out  AW  data-memory address
mem_wdat  out  DW  data-memory write data
mem_rdat  in  DW  data-memory read data (combinational read)
core_reset  out  1  active-high reset to core
core_req  out  1  one-cycle start pulse to core
core_done  in  1  core done level
busy  out  1  run in progress
host_done  out  1  run complete, held until next host_start
timeout  out  1  watchdog fired (held with host_done)
run_cycles  out  CW  RUN-state cycle count, saturating

Behaviour:
- Reset low: state IDLE, counters 0. Outputs 0 except core_reset=1 and mem_sel=1.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE/DONE on host_start:
  - Clear counters, host_done, timeout.
  - Go to LOAD; go to RUN if LOAD_LEN=0.
  - host_start is ignored in LOAD/RUN/DRAIN.
- LOAD:
  - in_ready=1; mem_addr=LOAD_BASE+ld_cnt (mod 2^AW); mem_wdat=in_data.
  - mem_wr_en=in_valid & in_ready, combinational, same cycle.
  - Each accepted byte increments ld_cnt. On the LOAD_LEN-th accept, next state is RUN.
- RUN:
  - mem_sel=0, core_reset=0, in_ready=0.
  - core_req=1 in the first RUN cycle only.
  - run_cycles increments every RUN cycle and saturates at all-ones.
  - core_done=1 in any RUN cycle after the first: go to DRAIN, or DONE if RES_LEN=0.
  - core_done in the first RUN cycle is ignored (stale flag).
- DRAIN:
  - mem_sel=1, core_reset=1; mem_addr=RES_BASE+rd_cnt (mod 2^AW).
  - out_valid=1; out_data=mem_rdat, stable while stalled.
  - Each out_valid & out_ready increments rd_cnt. The RES_LEN-th handshake goes to DONE.
- DONE: busy=0, host_done=1, core_reset=1, mem_sel=1.
- busy=1 in LOAD, RUN and DRAIN.
- Reset asserted mid-run: immediate return to IDLE. Any in-flight byte is dropped; core_reset=1 asynchronously.

Optional Feature:
TIMEOUT_EN
- Defined: RUN exits to DONE with timeout=1 when run_cycles reaches TIMEOUT without core_done. The drain is skipped.
- Undefined: RUN waits indefinitely; timeout is tied to 0.
- Simultaneous core_done and timeout limit: core_done wins.

Decomposition:
- Package run_seq_pkg: state enum type, default base/length constants, DW/AW typedefs.
- One sub-module: seq_counter, a width-parameterised clear/enable/saturate counter. Used for ld_cnt, rd_cnt and run_cycles.

Test Plan:
- Load, LOAD_LEN=4:
  - Stimulus: bytes 0x11,0x22,0x33,0x44 with in_valid gaps.
  - Response: writes to addresses 0..3 only on handshake cycles, then core_reset falls and core_req pulses once.
- Drain, RES_LEN=2:
  - Stimulus: mem[64]=0xA5, mem[65]=0x5A; out_ready held low 3 cycles.
  - Response: out_data stays 0xA5 while stalled, 0x5A follows, then host_done=1 and busy=0.
- Done timing:
  - Stimulus: core_done asserted at RUN cycle 10.
  - Response: run_cycles=10 in DONE; host_start during RUN has no effect.
- Mid-load reset:
  - Stimulus: reset low after 2 of 4 bytes.
  - Response: IDLE, core_reset=1, in_ready=0; a new run restarts at LOAD_BASE.
- Zero lengths:
  - Stimulus: LOAD_LEN=0 and RES_LEN=0.
  - Response: IDLE→RUN→DONE, with no mem_wr_en and no out_valid.
- TIMEOUT_EN, TIMEOUT=8:
  - Stimulus: core_done held low.
  - Response: DONE after 8 RUN cycles with timeout=1 and no out_valid.
